return_addr_stack: RTL
======================

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of stack entries, power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port push, input, 1 bit: a call (JAL/JALR with rd = x1 or x5) retires this cycle.
REQ-005 The block SHALL have port push_addr, input, 32 bits: link value (pc + 4) to store.
REQ-006 The block SHALL have port pop, input, 1 bit: a return (JALR with rs1 = x1/x5, rd != rs1) retires this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: pipeline flush that invalidates the whole stack.
REQ-008 The block SHALL have port top_addr, output, 32 bits: predicted return address (entry at top of stack).
REQ-009 The block SHALL have port top_valid, output, 1 bit: stack non-empty.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of valid entries.
REQ-011 The block SHALL have port overflow, output, 1 bit: registered one-cycle pulse, oldest entry overwritten.
REQ-012 The block SHALL have port underflow, output, 1 bit: registered one-cycle pulse, pop on empty stack.

Function
REQ-013 The storage SHALL be a DEPTH x 32 circular buffer with top pointer tos (mod DEPTH) and occupancy count.
REQ-014 top_addr SHALL equal entry[tos] when count > 0 and 0 when count == 0, combinational from registered state only (zero-cycle read; no input-to-output path).
REQ-015 top_valid SHALL equal (count != 0).
REQ-016 All state updates SHALL take effect on the rising clk edge; inputs are sampled at that edge.
REQ-017 On push only: tos <= tos+1 mod DEPTH, entry[tos+1] <= push_addr, and count <= count+1, saturating at DEPTH.
REQ-018 On push only with count == DEPTH, the oldest entry SHALL be overwritten (wrap-around), count SHALL stay DEPTH, and overflow SHALL be 1 for the next cycle.
REQ-019 On pop only with count > 0: tos <= tos-1 mod DEPTH and count <= count-1.
REQ-020 On pop only with count == 0, tos and count SHALL be unchanged and underflow SHALL be 1 for the next cycle.
REQ-021 On push and pop together with count > 0 (co-routine swap), entry[tos] <= push_addr with tos and count unchanged.
REQ-022 On push and pop together with count == 0, the block SHALL behave as push only (count becomes 1) and SHALL NOT raise underflow.
REQ-023 flush SHALL have priority over push and pop: count <= 0, with tos and storage contents unchanged and no flag raised.
REQ-024 overflow and underflow SHALL be 0 on every cycle not caused per REQ-018/REQ-020.
REQ-025 push_addr SHALL be stored unmodified, all 32 bits.

Reset
REQ-026 Asserting rst SHALL immediately set count=0, tos=0, overflow=0, underflow=0, top_valid=0, top_addr=0, and all stats counters=0.
REQ-027 Storage entries SHALL NOT require reset; they are unobservable while count == 0.
REQ-028 A rst asserted mid-operation SHALL discard any push/pop sampled at the same edge.
REQ-029 Operation SHALL resume on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro RAS_STATS_EN SHALL gate the statistics logic.
REQ-031 With RAS_STATS_EN defined, outputs ovf_cnt (16 bits) and udf_cnt (16 bits) SHALL exist and SHALL increment once per overflow or underflow event, saturating at 0xFFFF.
REQ-032 Without RAS_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then push 0x0000_1004 -> next cycle: top_valid=1, top_addr=0x0000_1004, count=1.
REQ-034 Push 0x100,0x104,0x108, then pop x3 -> top_addr sequence 0x108,0x104,0x100 before each pop, then count=0, top_addr=0.
REQ-035 DEPTH=8: push 9 values 0x10..0x30 step 4 -> overflow pulse after the 9th push, count=8; 8 pops return 0x30 down to 0x14, then a 9th pop raises underflow (ovf_cnt=1, udf_cnt=1 with RAS_STATS_EN).
REQ-036 count=2 (top 0x200), push 0x300 and pop in the same cycle -> top_addr=0x300, count=2; on empty stack, the same input -> count=1, top_addr=0x300, no underflow.
REQ-037 count=3, assert flush together with push 0x400 -> count=0, top_valid=0; next push 0x500 -> top_addr=0x500, count=1.
REQ-038 Assert rst asynchronously mid-cycle with count=5 -> outputs go to reset values before the next edge, and a push sampled during rst is ignored.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return address stack: circular buffer of DEPTH link addresses with overflow/underflow pulses.
// Define RAS_STATS_EN to add saturating overflow/underflow event counters (ovf_cnt, udf_cnt).
module return_addr_stack #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [31:0]                push_addr,
    input  logic                       pop,
    input  logic                       flush,
    output logic [31:0]                top_addr,
    output logic                       top_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
`ifdef RAS_STATS_EN
    ,
    output logic [15:0]                ovf_cnt,
    output logic [15:0]                udf_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] tos_q, tos_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = tos_q;
        if (flush) begin
            // Contents and tos are kept; only occupancy is dropped.
            count_d = '0;
        end else if (push && pop && (count_q != '0)) begin
            wr_en = 1'b1;
        end else if (push) begin
            tos_d  = tos_q + PW'(1);
            wr_idx = tos_q + PW'(1);
            wr_en  = 1'b1;
            if (count_q == CW'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (count_q != '0) begin
                tos_d   = tos_q - PW'(1);
                count_d = count_q - CW'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write sampled while rst is high is discarded.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= push_addr;
        end
    end

    assign top_valid = (count_q != '0);
    assign top_addr  = top_valid ? mem_q[tos_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef RAS_STATS_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [15:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (overflow_d && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 16'd1;
        if (underflow_d && (udf_cnt_q != '1)) udf_cnt_d = udf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

endmodule
